// File: rtl/branch_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl_pkg
// Shared constants for the branch redirect controller: default address and
// counter widths, the two-state FSM encoding and a small state decode helper.
// Imported by the interface, the controller and the performance counters.
// ---------------------------------------------------------------------------
package branch_redirect_ctrl_pkg;

    localparam int BR_ADDR_W    = 32;
    localparam int BR_CNT_W     = 32;
    localparam int BR_STATE_BUS = 1;

    typedef logic [BR_STATE_BUS-1:0] br_state_t;

    localparam br_state_t BR_STATE_IDLE = 1'b0;
    localparam br_state_t BR_STATE_HOLD = 1'b1;

    // True while a redirect is being offered to the PC stage.
    function automatic logic br_is_hold(input br_state_t state);
        return (state == BR_STATE_HOLD);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl_if
// Bundles the ID-stage branch result, pipeline control inputs and the
// redirect outputs towards the PC/IF stages.
//   master : pipeline side (drives branch/stall/flush, observes redirect)
//   slave  : branch_redirect_ctrl
// Signals:
//   branch_flag, branch_addr  ID branch taken + resolved target
//   id_stall                  ID held this cycle
//   pc_ready                  PC stage can load a redirect
//   flush, flush_pc           exception/eret flush pulse + target
//   redirect_valid/addr       redirect offered to the PC stage
//   squash_if                 kill the wrong-path IF instruction
//   branch_stall              hold ID while a redirect is unaccepted
//   in_delay_slot             instruction entering ID is a delay slot
// ---------------------------------------------------------------------------
interface branch_redirect_ctrl_if
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W = BR_ADDR_W
);
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_addr;
    logic              id_stall;
    logic              pc_ready;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              squash_if;
    logic              branch_stall;
    logic              in_delay_slot;

    modport master (
        output branch_flag, branch_addr, id_stall, pc_ready, flush, flush_pc,
        input  redirect_valid, redirect_addr, squash_if, branch_stall, in_delay_slot
    );

    modport slave (
        input  branch_flag, branch_addr, id_stall, pc_ready, flush, flush_pc,
        output redirect_valid, redirect_addr, squash_if, branch_stall, in_delay_slot
    );

endinterface

// File: rtl/branch_redirect_ctrl_perf_cnt.sv
// ---------------------------------------------------------------------------
// branch_perf_cnt
// Two free-running wrap-around event counters (taken branches, redirect wait
// cycles). Only compiled when BRANCH_PERF_EN is defined; otherwise the
// controller ties its performance outputs to zero and no flops exist.
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   en_taken, en_wait    increment enables
//   cnt_taken, cnt_wait  counter values (wrap modulo 2^CNT_W)
// ---------------------------------------------------------------------------
`ifdef BRANCH_PERF_EN
module branch_perf_cnt
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int CNT_W = BR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_taken,
    input  logic             en_wait,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_wait
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] taken_r;
    logic [CNT_W-1:0] wait_r;

    // Event counters; natural overflow gives the wrap to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_r <= {CNT_W{1'b0}};
            wait_r  <= {CNT_W{1'b0}};
        end else begin
            if (en_taken) begin
                taken_r <= taken_r + ONE;
            end else begin
                taken_r <= taken_r;
            end
            if (en_wait) begin
                wait_r <= wait_r + ONE;
            end else begin
                wait_r <= wait_r;
            end
        end
    end

    assign cnt_taken = taken_r;
    assign cnt_wait  = wait_r;

endmodule
`endif

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
// Sequences ID-stage branch resolution into the PC stage. A taken branch
// accepted from ID is latched and offered as a redirect (HOLD) until the PC
// stage takes it; ID is held meanwhile. The instruction after the branch is
// the MIPS delay slot and is flagged, never squashed. Flushes pre-empt any
// pending branch and reuse the same redirect handshake.
// Optional feature macro: BRANCH_PERF_EN (taken / wait-cycle counters).
// Ports:
//   clk         core clock
//   rst         synchronous active-high reset
//   br          branch_redirect_ctrl_if.slave (branch in, redirect out)
//   perf_taken  accepted-branch count (0 without BRANCH_PERF_EN)
//   perf_wait   cycles with redirect_valid && !pc_ready (0 without it)
// ---------------------------------------------------------------------------
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W = BR_ADDR_W,
    parameter int CNT_W  = BR_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_redirect_ctrl_if.slave br,
    output logic [CNT_W-1:0]      perf_taken,
    output logic [CNT_W-1:0]      perf_wait
);

    br_state_t         state_r;
    br_state_t         state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic              ds_r;
    logic              ds_nxt_s;
    logic              hold_s;
    logic              accept_s;

    assign hold_s = br_is_hold(state_r);

    // branch_stall blocks a second branch while one is pending, which also
    // makes a branch sitting in the delay slot fall on the floor.
    assign accept_s = br.branch_flag && !br.id_stall && !hold_s && !br.flush;

    // Next-state logic; flush overrides everything and discards any target.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        if (ds_r && !br.id_stall) begin
            ds_nxt_s = 1'b0;
        end else begin
            ds_nxt_s = ds_r;
        end

        if (br.flush) begin
            state_nxt_s = BR_STATE_HOLD;
            addr_nxt_s  = br.flush_pc;
            ds_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                BR_STATE_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = BR_STATE_HOLD;
                        addr_nxt_s  = br.branch_addr;
                        ds_nxt_s    = 1'b1;
                    end else begin
                        state_nxt_s = BR_STATE_IDLE;
                    end
                end
                BR_STATE_HOLD: begin
                    if (br.pc_ready) begin
                        state_nxt_s = BR_STATE_IDLE;
                    end else begin
                        state_nxt_s = BR_STATE_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = BR_STATE_IDLE;
                end
            endcase
        end
    end

    // State, redirect target and delay-slot flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= BR_STATE_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            ds_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            ds_r    <= ds_nxt_s;
        end
    end

    assign br.redirect_valid = hold_s;
    assign br.branch_stall   = hold_s;
    assign br.redirect_addr  = addr_r;
    assign br.in_delay_slot  = ds_r;
    // The PC stage consumes the redirect this cycle, so the instruction now
    // being fetched (the one after the delay slot) is wrong-path.
    assign br.squash_if      = hold_s && br.pc_ready;

`ifdef BRANCH_PERF_EN
    logic wait_s;

    assign wait_s = hold_s && !br.pc_ready;

    branch_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .en_taken  (accept_s),
        .en_wait   (wait_s),
        .cnt_taken (perf_taken),
        .cnt_wait  (perf_wait)
    );
`else
    assign perf_taken = {CNT_W{1'b0}};
    assign perf_wait  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
// Self-checking bench for branch_redirect_ctrl. Each row gives the inputs for
// one cycle and the outputs expected during that cycle. Build with
// BRANCH_PERF_EN defined to also exercise the performance counters.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    localparam int AW = 32;
    localparam int CW = 4;

    localparam logic [AW-1:0] A = 32'hBFC0_0100;
    localparam logic [AW-1:0] B = 32'h8000_0400;
    localparam logic [AW-1:0] F = 32'hBFC0_0380;
    localparam logic [AW-1:0] C = 32'h1234_5678;
    localparam logic [AW-1:0] D = 32'h0000_0004;
    localparam logic [AW-1:0] Z = 32'h0000_0000;

    typedef struct packed {
        logic          bf;
        logic [AW-1:0] ba;
        logic          ids;
        logic          pr;
        logic          fl;
        logic [AW-1:0] fpc;
    } in_t;

    typedef struct packed {
        logic          rv;
        logic [AW-1:0] ra;
        logic          sq;
        logic          bs;
        logic          ds;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] perf_taken;
    logic [CW-1:0] perf_wait;

    vec_t vecs[$];
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    branch_redirect_ctrl_if #(.ADDR_W(AW)) br();

    branch_redirect_ctrl #(
        .ADDR_W (AW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br         (br),
        .perf_taken (perf_taken),
        .perf_wait  (perf_wait)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(input logic bf, input logic [AW-1:0] ba, input logic ids,
                                  input logic pr, input logic fl, input logic [AW-1:0] fpc);
        in_t v;
        v.bf = bf; v.ba = ba; v.ids = ids; v.pr = pr; v.fl = fl; v.fpc = fpc;
        return v;
    endfunction

    function automatic out_t mk_out(input logic rv, input logic [AW-1:0] ra, input logic sq,
                                    input logic bs, input logic ds);
        out_t v;
        v.rv = rv; v.ra = ra; v.sq = sq; v.bs = bs; v.ds = ds;
        return v;
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endtask

    // Apply inputs for one cycle at the falling edge; outputs settle 1ns later.
    task automatic drive(input in_t v);
        @(negedge clk);
        br.branch_flag = v.bf;
        br.branch_addr = v.ba;
        br.id_stall    = v.ids;
        br.pc_ready    = v.pr;
        br.flush       = v.fl;
        br.flush_pc    = v.fpc;
        #1;
    endtask

    task automatic check_out(input string name);
        out_t a;
        out_t e;
        a = mk_out(br.redirect_valid, br.redirect_addr, br.squash_if, br.branch_stall,
                   br.in_delay_slot);
        e = exp_q.pop_front();
        n_checks++;
        if (a === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rv=%0b addr=%h sq=%0b bs=%0b ds=%0b, want rv=%0b addr=%h sq=%0b bs=%0b ds=%0b",
                     name, a.rv, a.ra, a.sq, a.bs, a.ds, e.rv, e.ra, e.sq, e.bs, e.ds);
        end
    endtask

    task automatic check_val(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic step_check(input in_t i, input out_t o, input string name);
        drive(i);
        exp_q.push_back(o);
        check_out(name);
    endtask

    initial begin
        br.branch_flag = 1'b0;
        br.branch_addr = Z;
        br.id_stall    = 1'b0;
        br.pc_ready    = 1'b0;
        br.flush       = 1'b0;
        br.flush_pc    = Z;

        //        bf    addr ids   pr    fl    fpc        rv    addr sq    bs    ds
        // 1: taken branch, PC ready at once
        add(mk_in(1'b1, A, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, Z, 1'b0, 1'b0, 1'b0));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b1, A, 1'b1, 1'b1, 1'b1));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, A, 1'b0, 1'b0, 1'b0));
        // 2: PC not ready for 3 cycles, delay slot held by ID stall
        add(mk_in(1'b1, B, 1'b0, 1'b0, 1'b0, Z), mk_out(1'b0, A, 1'b0, 1'b0, 1'b0));
        add(mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z), mk_out(1'b1, B, 1'b0, 1'b1, 1'b1));
        add(mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z), mk_out(1'b1, B, 1'b0, 1'b1, 1'b1));
        add(mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z), mk_out(1'b1, B, 1'b0, 1'b1, 1'b1));
        add(mk_in(1'b0, Z, 1'b1, 1'b1, 1'b0, Z), mk_out(1'b1, B, 1'b1, 1'b1, 1'b1));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, B, 1'b0, 1'b0, 1'b1));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, B, 1'b0, 1'b0, 1'b0));
        // 3: branch held off by id_stall for two cycles
        add(mk_in(1'b1, C, 1'b1, 1'b1, 1'b0, Z), mk_out(1'b0, B, 1'b0, 1'b0, 1'b0));
        add(mk_in(1'b1, C, 1'b1, 1'b1, 1'b0, Z), mk_out(1'b0, B, 1'b0, 1'b0, 1'b0));
        add(mk_in(1'b1, C, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, B, 1'b0, 1'b0, 1'b0));
        add(mk_in(1'b0, Z, 1'b1, 1'b1, 1'b0, Z), mk_out(1'b1, C, 1'b1, 1'b1, 1'b1));
        add(mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z), mk_out(1'b0, C, 1'b0, 1'b0, 1'b1));
        add(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z), mk_out(1'b0, C, 1'b0, 1'b0, 1'b1));
        add(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z), mk_out(1'b0, C, 1'b0, 1'b0, 1'b0));
        // 4: flush while a branch is held
        add(mk_in(1'b1, B, 1'b0, 1'b0, 1'b0, Z), mk_out(1'b0, C, 1'b0, 1'b0, 1'b0));
        add(mk_in(1'b0, Z, 1'b1, 1'b0, 1'b1, F), mk_out(1'b1, B, 1'b0, 1'b1, 1'b1));
        add(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z), mk_out(1'b1, F, 1'b0, 1'b1, 1'b0));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b1, F, 1'b1, 1'b1, 1'b0));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, F, 1'b0, 1'b0, 1'b0));
        // 5: flush and branch in the same cycle
        add(mk_in(1'b1, C, 1'b0, 1'b1, 1'b1, D), mk_out(1'b0, F, 1'b0, 1'b0, 1'b0));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b1, D, 1'b1, 1'b1, 1'b0));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, D, 1'b0, 1'b0, 1'b0));
        // flush arriving as the PC stage accepts a branch redirect
        add(mk_in(1'b1, A, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, D, 1'b0, 1'b0, 1'b0));
        add(mk_in(1'b0, Z, 1'b1, 1'b1, 1'b1, F), mk_out(1'b1, A, 1'b1, 1'b1, 1'b1));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b1, F, 1'b1, 1'b1, 1'b0));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, F, 1'b0, 1'b0, 1'b0));
        // branch presented during HOLD is ignored
        add(mk_in(1'b1, B, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, F, 1'b0, 1'b0, 1'b0));
        add(mk_in(1'b1, C, 1'b0, 1'b0, 1'b0, Z), mk_out(1'b1, B, 1'b0, 1'b1, 1'b1));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b1, B, 1'b1, 1'b1, 1'b0));
        add(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, B, 1'b0, 1'b0, 1'b0));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        exp_q.push_back(mk_out(1'b0, Z, 1'b0, 1'b0, 1'b0));
        check_out("reset");
        check_val("reset_perf_taken", perf_taken, 4'd0);
        check_val("reset_perf_wait", perf_wait, 4'd0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            step_check(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));
        end

`ifdef BRANCH_PERF_EN
        check_val("table_perf_taken", perf_taken, 4'd6);
        check_val("table_perf_wait", perf_wait, 4'd6);
`else
        check_val("table_perf_taken", perf_taken, 4'd0);
        check_val("table_perf_wait", perf_wait, 4'd0);
`endif

        // 6: reset while a redirect is held; no squash afterwards
        step_check(mk_in(1'b1, A, 1'b0, 1'b0, 1'b0, Z), mk_out(1'b0, B, 1'b0, 1'b0, 1'b0), "rst_pre_accept");
        step_check(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z), mk_out(1'b1, A, 1'b0, 1'b1, 1'b1), "rst_pre_hold");
        rst = 1'b1;
        step_check(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, Z, 1'b0, 1'b0, 1'b0), "rst_mid_hold");
        rst = 1'b0;
        step_check(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, Z, 1'b0, 1'b0, 1'b0), "post_rst");
        check_val("post_rst_perf_taken", perf_taken, 4'd0);
        check_val("post_rst_perf_wait", perf_wait, 4'd0);

`ifdef BRANCH_PERF_EN
        for (int n = 0; n < 5; n++) begin
            drive(mk_in(1'b1, A, 1'b0, 1'b1, 1'b0, Z));
            drive(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z));
        end
        check_val("perf_taken_5", perf_taken, 4'd5);
        for (int n = 0; n < 10; n++) begin
            drive(mk_in(1'b1, A, 1'b0, 1'b1, 1'b0, Z));
            drive(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z));
        end
        check_val("perf_taken_max", perf_taken, 4'd15);
        drive(mk_in(1'b1, A, 1'b0, 1'b1, 1'b0, Z));
        drive(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z));
        check_val("perf_taken_wrap", perf_taken, 4'd0);
        check_val("perf_wait_none", perf_wait, 4'd0);

        drive(mk_in(1'b1, C, 1'b0, 1'b0, 1'b0, Z));
        for (int n = 0; n < 15; n++) begin
            drive(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z));
        end
        drive(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z));
        check_val("perf_wait_max", perf_wait, 4'd15);
        drive(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b0, Z));
        check_val("perf_wait_wrap", perf_wait, 4'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
